hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RV32I core. It drives the stall and flush controls of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding selects. It sequences two multi-cycle events: a data-memory wait (M stage) and a fixed-latency multiply/divide unit (E stage). Internally it is a small FSM with a latency counter.

Parameters:
DATA_WIDTH, 32, datapath width; carried for consistency, no datapath logic in this block
MDU_LATENCY, 4, total MDU cycles from start to result-valid; legal range 2..15

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
rs1_d  in  5  D-stage source register 1
rs2_d  in  5  D-stage source register 2
rs1_e  in  5  E-stage source register 1
rs2_e  in  5  E-stage source register 2
rd_e  in  5  E-stage destination
rd_m  in  5  M-stage destination
rd_w  in  5  W-stage destination
reg_write_m  in  1  M-stage instruction writes rd
reg_write_w  in  1  W-stage instruction writes rd
load_e  in  1  E-stage instruction is a load
pc_src_e  in  1  taken branch or jump resolved in E
mdu_start_e  in  1  E-stage instruction is a MUL/DIV (level, held while E is stalled)
mem_req_m  in  1  M-stage load or store active
mem_ready  in  1  data memory completes the M-stage access this cycle
stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register
flush_d, flush_e, flush_m  out  1 each  zero the corresponding pipeline register
forward_a_e, forward_b_e  out  2 each  00 = register file, 01 = W result, 10 = M ALU result
mdu_done  out  1  single-cycle pulse: MDU result valid in E this cycle

Behaviour:
- FSM states are IDLE, MEM_WAIT and MDU_BUSY. The 4-bit counter cnt is used in MDU_BUSY.
- Reset: while rst=1, state<=IDLE and cnt<=0. All stall outputs, flush_m, mdu_done and the forward selects are 0. flush_d=flush_e=1 so bubbles enter the pipe. Reset mid-MDU or mid-MEM_WAIT abandons the operation; no mdu_done is issued.
- Forwarding is combinational and independent of state. For operand A: 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e; else 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e; else 00. M wins over W. Operand B is the same rule using rs2_e.
- Load-use hazard: lw = load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d). Response: stall_f=stall_d=1 and flush_e=1, for exactly 1 cycle.
- Control hazard: pc_src_e drives flush_d=flush_e=1 for 1 cycle. Flush takes precedence over stall on the same register.
- Memory freeze: freeze = mem_req_m && !mem_ready, evaluated in any state.
  - IDLE with freeze: next state is MEM_WAIT.
  - MEM_WAIT with mem_ready: next state is IDLE.
  - While freeze=1: stall_f=stall_d=stall_e=stall_m=1 and all flushes=0, including those from pc_src_e and lw. Those hazards are re-evaluated after release because E is held.
  - cnt holds during freeze.
  - A zero-wait access (mem_req_m && mem_ready) causes no stall.
- MDU sequencing:
  - IDLE, mdu_start_e=1, no freeze: stall_f=stall_d=stall_e=1 and flush_m=1 this cycle; cnt<=MDU_LATENCY-1; next state MDU_BUSY.
  - MDU_BUSY with cnt>1: same stall/flush outputs; cnt decrements.
  - MDU_BUSY with cnt==1: no stall; mdu_done=1; next state IDLE. The E instruction advances this cycle.
  - Net effect: exactly MDU_LATENCY-1 stall cycles, with mdu_done in cycle start+MDU_LATENCY-1.
  - mdu_start_e is ignored outside IDLE. Back-to-back MDU instructions re-trigger from IDLE on the next start.
- Output priority, highest first: rst, freeze, MDU stall, lw, pc_src_e. pc_src_e and lw can both be active only when the E instruction is a non-load branch; in that case lw is false and branch flush applies.
- A load in E whose rd matches D while a freeze is active keeps its stall after the freeze releases.

Test Plan:
- Forwarding: rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 -> forward_a_e=10. Same with rd_m=0 -> 01. rs2_e=0 with rd_w=0 -> forward_b_e=00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle. Next cycle with load_e=0 -> all outputs 0.
- Branch: pc_src_e=1 -> flush_d=flush_e=1, no stalls. Repeat with mem_req_m=1, mem_ready=0 -> all four stalls=1 and flushes=0 until mem_ready.
- Memory wait: mem_req_m=1, mem_ready low for 3 cycles then high -> stalls high 3 cycles, state returns to IDLE, zero stalls on the ready cycle.
- MDU with MDU_LATENCY=4: mdu_start_e held -> stall_f/d/e and flush_m high 3 cycles, then mdu_done=1 and no stall on the 4th cycle. Freeze injected during busy -> completion delayed by the freeze length.
- Reset during MDU_BUSY (cycle 2) -> next cycle IDLE, flush_d=flush_e=1 while rst, and mdu_done never asserts.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stall/flush
// generation, E-stage forwarding selects, data-memory wait and fixed-latency MDU sequencing.
module hazard_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int MDU_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       load_e,
    input  logic       pc_src_e,
    input  logic       mdu_start_e,
    input  logic       mem_req_m,
    input  logic       mem_ready,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       mdu_done
);

    if (DATA_WIDTH < 1 || MDU_LATENCY < 2 || MDU_LATENCY > 15) begin : g_param_check
        $error("hazard_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MDU_LATENCY - 1);

    // Valid/ready note: mem_req_m is the request, mem_ready the completion strobe;
    // an access completes in the cycle both are high, so the pipe is frozen only while
    // a request is pending without ready.

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       freeze;
    logic       lw;
    logic       hazard_en;

    assign freeze = mem_req_m && !mem_ready;
    assign lw     = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        forward_a_e = 2'b00;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e) begin
            forward_a_e = 2'b10;
        end else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) begin
            forward_a_e = 2'b01;
        end
        forward_b_e = 2'b00;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e) begin
            forward_b_e = 2'b10;
        end else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) begin
            forward_b_e = 2'b01;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        mdu_done  = 1'b0;
        hazard_en = 1'b0;

        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (freeze) begin
            // Whole pipe holds; the MDU counter pauses with it.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            if (state_q == IDLE) begin
                state_d = MEM_WAIT;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdu_start_e) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = MDU_BUSY;
                    end else begin
                        hazard_en = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    state_d   = IDLE;
                    hazard_en = 1'b1;
                end
                MDU_BUSY: begin
                    if (cnt_q > 4'd1) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        cnt_d   = cnt_q - 4'd1;
                    end else begin
                        mdu_done  = 1'b1;
                        state_d   = IDLE;
                        hazard_en = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Load-use outranks a branch; a load is never the branch itself.
        if (hazard_en) begin
            if (lw) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_LATENCY=4): forwarding, load-use, branch,
// memory freeze, MDU sequencing and reset abort, with hand-computed expectations.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_m, reg_write_w, load_e, pc_src_e, mdu_start_e;
    logic       mem_req_m, mem_ready;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m, mdu_done;
    logic [1:0] forward_a_e, forward_b_e;

    int n_total = 0;
    int n_bad   = 0;

    // Control bundle order: stall_f stall_d stall_e stall_m flush_d flush_e flush_m mdu_done
    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_RST    = 8'b0000_1100;
    localparam logic [7:0] C_BRANCH = 8'b0000_1100;
    localparam logic [7:0] C_LW     = 8'b1100_0100;
    localparam logic [7:0] C_FREEZE = 8'b1111_0000;
    localparam logic [7:0] C_MDU    = 8'b1110_0010;
    localparam logic [7:0] C_DONE   = 8'b0000_0001;

    hazard_ctrl #(.DATA_WIDTH(32), .MDU_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .pc_src_e(pc_src_e), .mdu_start_e(mdu_start_e),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .mdu_done(mdu_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [7:0] exp);
        #1;
        check(tag, {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, mdu_done}, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_m = 0; reg_write_w = 0; load_e = 0; pc_src_e = 0; mdu_start_e = 0;
        mem_req_m = 0; mem_ready = 0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        cyc();
        cyc();
        chk_ctl("reset_ctl", C_RST);
        check("reset_fwd", {4'd0, forward_a_e, forward_b_e}, 8'd0);
        rst = 1'b0;
        chk_ctl("idle_after_reset", C_NONE);
        cyc();

        // Forwarding
        reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5; rs1_e = 5;
        #1 check("fwd_a_m_wins", {6'd0, forward_a_e}, 8'd2);
        rd_m = 0;
        #1 check("fwd_a_w", {6'd0, forward_a_e}, 8'd1);
        rs2_e = 0; rd_w = 0;
        #1 check("fwd_b_x0", {6'd0, forward_b_e}, 8'd0);
        reg_write_m = 0; rd_m = 9; reg_write_w = 1; rd_w = 9; rs2_e = 9;
        #1 check("fwd_b_w_only", {6'd0, forward_b_e}, 8'd1);
        reg_write_m = 1;
        #1 check("fwd_b_m", {6'd0, forward_b_e}, 8'd2);
        clr();
        cyc();

        // Load-use
        load_e = 1; rd_e = 7; rs2_d = 7;
        chk_ctl("lw_stall", C_LW);
        cyc();
        load_e = 0;
        chk_ctl("lw_release", C_NONE);
        load_e = 1; rd_e = 0; rs1_d = 0;
        chk_ctl("lw_x0", C_NONE);
        clr();
        cyc();

        // Branch, then branch under freeze
        pc_src_e = 1;
        chk_ctl("branch", C_BRANCH);
        cyc();
        mem_req_m = 1; mem_ready = 0;
        chk_ctl("branch_freeze0", C_FREEZE);
        cyc();
        chk_ctl("branch_freeze1", C_FREEZE);
        cyc();
        mem_ready = 1;
        chk_ctl("branch_after_freeze", C_BRANCH);
        cyc();
        clr();
        chk_ctl("branch_clear", C_NONE);
        cyc();

        // Memory wait: three wait cycles then ready
        mem_req_m = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("mem_wait", C_FREEZE);
            cyc();
        end
        mem_ready = 1;
        chk_ctl("mem_ready_cycle", C_NONE);
        cyc();
        mem_req_m = 0; mem_ready = 0;
        chk_ctl("mem_idle", C_NONE);
        mem_req_m = 1; mem_ready = 1;
        chk_ctl("mem_zero_wait", C_NONE);
        clr();
        cyc();

        // Load-use held across a freeze
        load_e = 1; rd_e = 4; rs1_d = 4; mem_req_m = 1; mem_ready = 0;
        chk_ctl("lw_in_freeze", C_FREEZE);
        cyc();
        mem_ready = 1;
        chk_ctl("lw_after_freeze", C_LW);
        clr();
        cyc();

        // MDU, latency 4: three stall cycles then done
        mdu_start_e = 1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("mdu_stall", C_MDU);
            cyc();
        end
        chk_ctl("mdu_done", C_DONE);
        cyc();
        mdu_start_e = 0;
        chk_ctl("mdu_after_done", C_NONE);
        cyc();

        // MDU with a two-cycle freeze while busy
        mdu_start_e = 1;
        chk_ctl("mduf_start", C_MDU);
        cyc();
        mem_req_m = 1; mem_ready = 0;
        chk_ctl("mduf_freeze0", C_FREEZE);
        cyc();
        chk_ctl("mduf_freeze1", C_FREEZE);
        cyc();
        mem_req_m = 0;
        chk_ctl("mduf_resume0", C_MDU);
        cyc();
        chk_ctl("mduf_resume1", C_MDU);
        cyc();
        chk_ctl("mduf_done", C_DONE);
        cyc();

        // Back-to-back start, then reset on the second busy cycle
        chk_ctl("mdu_b2b_start", C_MDU);
        cyc();
        rst = 1;
        chk_ctl("mdu_reset_ctl", C_RST);
        cyc();
        rst = 0; mdu_start_e = 0;
        for (int i = 0; i < 4; i++) begin
            chk_ctl("mdu_aborted", C_NONE);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
